// File: rtl/life_pkg.sv
// Shared Game of Life types and board dimensions.
// Used by the cell array and by board_monitor.
package life_pkg;

    localparam int LIFE_ROWS = 16;
    localparam int LIFE_COLS = 16;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        EXTINCT,
        STABLE,
        OSC2
    } mon_state_t;

    typedef logic [LIFE_ROWS-1:0][LIFE_COLS-1:0] board_t;

endpackage

// File: rtl/board_monitor_if.sv
// Board observation bundle between the life top level and board_monitor.
// master drives load/tick/board; slave is the monitor reporting status.
interface board_monitor_if #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int GEN_W = 16
);
    localparam int POP_W = $clog2(ROWS * COLS + 1);

    logic                       load;
    logic                       tick;
    logic [ROWS-1:0][COLS-1:0]  board;
    logic [GEN_W-1:0]           gen_count;
    logic [POP_W-1:0]           population;
    logic                       extinct;
    logic                       stable;
    logic                       osc2;
    logic                       done;

    modport master (
        output load, tick, board,
        input  gen_count, population, extinct, stable, osc2, done
    );

    modport slave (
        input  load, tick, board,
        output gen_count, population, extinct, stable, osc2, done
    );

endinterface

// File: rtl/board_monitor_pop_counter.sv
// pop_counter: combinational live-cell count of a whole board.
// Per-row partial sums feed a final accumulation across rows.
module pop_counter #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int CNT_W = $clog2(ROWS * COLS + 1)
) (
    input  logic [ROWS-1:0][COLS-1:0] board,
    output logic [CNT_W-1:0]          count
);

    logic [CNT_W-1:0] row_sum;

    // Sum each row, then add the row sums together
    always_comb begin
        count   = '0;
        row_sum = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_sum = '0;
            for (int c = 0; c < COLS; c++) begin
                row_sum = row_sum + CNT_W'(board[r][c]);
            end
            count = count + row_sum;
        end
    end

endmodule

// File: rtl/board_monitor.sv
// board_monitor: generation/population tracker with extinction, still-life
// and (with BOARD_MONITOR_OSC2_DETECT_EN) period-2 oscillation detection.
module board_monitor
    import life_pkg::*;
#(
    parameter int ROWS  = LIFE_ROWS,
    parameter int COLS  = LIFE_COLS,
    parameter int GEN_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    board_monitor_if.slave bus
);

    localparam int POP_W = $clog2(ROWS * COLS + 1);

    typedef logic [ROWS-1:0][COLS-1:0] brd_t;

    mon_state_t       state_q, state_d;
    logic [GEN_W-1:0] gen_q, gen_d, gen_inc;
    logic [POP_W-1:0] pop_q, pop_d, pop_now;
    logic             ext_q, ext_d;
    logic             stb_q, stb_d;
    logic             done_q, done_d;
    brd_t             prev1_q, prev1_d;
    logic             zero_brd;
    logic             same1;
`ifdef BOARD_MONITOR_OSC2_DETECT_EN
    brd_t             prev2_q, prev2_d;
    logic             hist_q, hist_d;
    logic             osc_q, osc_d;
    logic             same2;
`endif

    pop_counter #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .CNT_W (POP_W)
    ) u_pop (
        .board (bus.board),
        .count (pop_now)
    );

    assign zero_brd = (bus.board == '0);
    assign same1    = (bus.board == prev1_q);
    assign gen_inc  = (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);
`ifdef BOARD_MONITOR_OSC2_DETECT_EN
    assign same2    = (bus.board == prev2_q);
`endif

    // Next-state: load clears everything, tick advances the FSM
    always_comb begin
        state_d = state_q;
        gen_d   = gen_q;
        pop_d   = pop_q;
        ext_d   = ext_q;
        stb_d   = stb_q;
        done_d  = 1'b0;
        prev1_d = prev1_q;
`ifdef BOARD_MONITOR_OSC2_DETECT_EN
        prev2_d = prev2_q;
        hist_d  = hist_q;
        osc_d   = osc_q;
`endif
        if (bus.load) begin
            state_d = IDLE;
            gen_d   = '0;
            pop_d   = '0;
            ext_d   = 1'b0;
            stb_d   = 1'b0;
            prev1_d = '0;
`ifdef BOARD_MONITOR_OSC2_DETECT_EN
            prev2_d = '0;
            hist_d  = 1'b0;
            osc_d   = 1'b0;
`endif
        end else if (bus.tick) begin
            pop_d = pop_now;
            case (state_q)
                IDLE: begin
                    gen_d   = gen_inc;
                    prev1_d = bus.board;
                    if (zero_brd) begin
                        state_d = EXTINCT;
                        ext_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    gen_d   = gen_inc;
                    prev1_d = bus.board;
`ifdef BOARD_MONITOR_OSC2_DETECT_EN
                    prev2_d = prev1_q;
                    hist_d  = 1'b1;
`endif
                    if (zero_brd) begin
                        state_d = EXTINCT;
                        ext_d   = 1'b1;
                        done_d  = 1'b1;
                    end else if (same1) begin
                        state_d = STABLE;
                        stb_d   = 1'b1;
                        done_d  = 1'b1;
                    end
`ifdef BOARD_MONITOR_OSC2_DETECT_EN
                    else if (hist_q && same2) begin
                        state_d = OSC2;
                        osc_d   = 1'b1;
                        done_d  = 1'b1;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // State, counters and history registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gen_q   <= '0;
            pop_q   <= '0;
            ext_q   <= 1'b0;
            stb_q   <= 1'b0;
            done_q  <= 1'b0;
            prev1_q <= '0;
`ifdef BOARD_MONITOR_OSC2_DETECT_EN
            prev2_q <= '0;
            hist_q  <= 1'b0;
            osc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gen_q   <= gen_d;
            pop_q   <= pop_d;
            ext_q   <= ext_d;
            stb_q   <= stb_d;
            done_q  <= done_d;
            prev1_q <= prev1_d;
`ifdef BOARD_MONITOR_OSC2_DETECT_EN
            prev2_q <= prev2_d;
            hist_q  <= hist_d;
            osc_q   <= osc_d;
`endif
        end
    end

    assign bus.gen_count  = gen_q;
    assign bus.population = pop_q;
    assign bus.extinct    = ext_q;
    assign bus.stable     = stb_q;
    assign bus.done       = done_q;
`ifdef BOARD_MONITOR_OSC2_DETECT_EN
    assign bus.osc2       = osc_q;
`else
    assign bus.osc2       = 1'b0;
`endif

endmodule

// File: tb/tb_board_monitor.sv
// Scoreboard bench for board_monitor (default and GEN_W=4 instances).
// Expectations follow BOARD_MONITOR_OSC2_DETECT_EN when it is defined.
module tb_board_monitor;
    import life_pkg::*;

    typedef struct packed {
        logic [15:0] gen;
        logic [8:0]  pop;
        logic        ext;
        logic        stb;
        logic        osc;
        logic        done;
    } obs_t;

    typedef struct {
        logic   r;
        logic   l;
        logic   t;
        board_t b;
        obs_t   e;
    } stim_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    board_monitor_if #(.ROWS(16), .COLS(16), .GEN_W(16)) bus ();
    board_monitor_if #(.ROWS(16), .COLS(16), .GEN_W(4))  bus4 ();

    board_monitor #(.GEN_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    board_monitor #(.GEN_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    int     errors = 0;
    int     checks = 0;
    obs_t   sbq[$];
    board_t b_zero, b_blk, b_h, b_v;

    function automatic obs_t mk(int g, int p, logic e, logic s,
                                logic o, logic d);
        obs_t x;
        x.gen  = 16'(g);
        x.pop  = 9'(p);
        x.ext  = e;
        x.stb  = s;
        x.osc  = o;
        x.done = d;
        return x;
    endfunction

    function automatic stim_t st(logic r, logic l, logic t, board_t b,
                                 obs_t e);
        stim_t x;
        x.r = r;
        x.l = l;
        x.t = t;
        x.b = b;
        x.e = e;
        return x;
    endfunction

    function automatic obs_t sample();
        obs_t x;
        x.gen  = bus.gen_count;
        x.pop  = bus.population;
        x.ext  = bus.extinct;
        x.stb  = bus.stable;
        x.osc  = bus.osc2;
        x.done = bus.done;
        return x;
    endfunction

    function automatic obs_t sample4();
        obs_t x;
        x.gen  = 16'(bus4.gen_count);
        x.pop  = bus4.population;
        x.ext  = bus4.extinct;
        x.stb  = bus4.stable;
        x.osc  = bus4.osc2;
        x.done = bus4.done;
        return x;
    endfunction

    task automatic drive(input logic r, input logic l, input logic t,
                         input board_t b);
        @(negedge clk);
        reset     = r;
        bus.load  = l;
        bus.tick  = t;
        bus.board = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s[$];
        obs_t  got, exp_v;
        s.push_back(st(1, 0, 0, b_zero, mk(0, 0, 0, 0, 0, 0)));
        s.push_back(st(1, 0, 0, b_zero, mk(0, 0, 0, 0, 0, 0)));
        s.push_back(st(0, 1, 0, b_zero, mk(0, 0, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 1, b_h,    mk(1, 3, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 1, b_v,    mk(2, 3, 0, 0, 0, 0)));
        s.push_back(st(1, 0, 0, b_v,    mk(0, 0, 0, 0, 0, 0)));
        s.push_back(st(1, 0, 1, b_h,    mk(0, 0, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 1, b_h,    mk(1, 3, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 1, b_h,    mk(2, 3, 0, 1, 0, 1)));
        s.push_back(st(0, 0, 0, b_zero, mk(2, 3, 0, 1, 0, 0)));
        foreach (s[i]) begin
            sbq.push_back(s[i].e);
            drive(s[i].r, s[i].l, s[i].t, s[i].b);
            got   = sample();
            exp_v = sbq.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset[%0d] got=%h want=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_extinction();
        stim_t s[$];
        obs_t  got, exp_v;
        s.push_back(st(0, 1, 0, b_zero, mk(0, 0, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 1, b_zero, mk(1, 0, 1, 0, 0, 1)));
        s.push_back(st(0, 0, 1, b_blk,  mk(1, 4, 1, 0, 0, 0)));
        s.push_back(st(0, 0, 1, b_zero, mk(1, 0, 1, 0, 0, 0)));
        s.push_back(st(0, 0, 0, b_blk,  mk(1, 0, 1, 0, 0, 0)));
        foreach (s[i]) begin
            sbq.push_back(s[i].e);
            drive(s[i].r, s[i].l, s[i].t, s[i].b);
            got   = sample();
            exp_v = sbq.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL extinct[%0d] got=%h want=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_still_life();
        stim_t s[$];
        obs_t  got, exp_v;
        s.push_back(st(0, 1, 0, b_zero, mk(0, 0, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 1, b_blk,  mk(1, 4, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 1, b_blk,  mk(2, 4, 0, 1, 0, 1)));
        s.push_back(st(0, 0, 1, b_blk,  mk(2, 4, 0, 1, 0, 0)));
        foreach (s[i]) begin
            sbq.push_back(s[i].e);
            drive(s[i].r, s[i].l, s[i].t, s[i].b);
            got   = sample();
            exp_v = sbq.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL still[%0d] got=%h want=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_osc2();
        obs_t   got, exp_v;
        board_t b;
        drive(0, 1, 0, b_zero);
        for (int i = 0; i < 10; i++) begin
            b = (i % 2 == 0) ? b_h : b_v;
`ifdef BOARD_MONITOR_OSC2_DETECT_EN
            sbq.push_back(mk((i < 3) ? i + 1 : 3, 3, 0, 0,
                             logic'(i >= 2), logic'(i == 2)));
`else
            sbq.push_back(mk(i + 1, 3, 0, 0, 0, 0));
`endif
            drive(0, 0, 1, b);
            got   = sample();
            exp_v = sbq.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL osc2[%0d] got=%h want=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_load_tick();
        stim_t s[$];
        obs_t  got, exp_v;
        s.push_back(st(0, 1, 0, b_zero, mk(0, 0, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 1, b_h,    mk(1, 3, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 1, b_v,    mk(2, 3, 0, 0, 0, 0)));
        s.push_back(st(0, 1, 1, b_h,    mk(0, 0, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 1, b_v,    mk(1, 3, 0, 0, 0, 0)));
        s.push_back(st(0, 0, 1, b_v,    mk(2, 3, 0, 1, 0, 1)));
        s.push_back(st(0, 1, 0, b_zero, mk(0, 0, 0, 0, 0, 0)));
        foreach (s[i]) begin
            sbq.push_back(s[i].e);
            drive(s[i].r, s[i].l, s[i].t, s[i].b);
            got   = sample();
            exp_v = sbq.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL loadtick[%0d] got=%h want=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_saturation();
        obs_t   got, exp_v;
        board_t b;
        @(negedge clk);
        bus4.load = 1'b1;
        @(negedge clk);
        bus4.load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            b = '0;
            b[i / 16][i % 16] = 1'b1;
            sbq.push_back(mk((i + 1 > 15) ? 15 : i + 1, 1, 0, 0, 0, 0));
            @(negedge clk);
            bus4.tick  = 1'b1;
            bus4.board = b;
            @(posedge clk);
            #1;
            got   = sample4();
            exp_v = sbq.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL sat[%0d] got=%h want=%h", i, got, exp_v);
            end
        end
        @(negedge clk);
        bus4.tick = 1'b0;
    endtask

    initial begin
        b_zero = '0;
        b_blk  = '0;
        b_blk[5][5] = 1'b1;
        b_blk[5][6] = 1'b1;
        b_blk[6][5] = 1'b1;
        b_blk[6][6] = 1'b1;
        b_h = '0;
        b_h[8][7] = 1'b1;
        b_h[8][8] = 1'b1;
        b_h[8][9] = 1'b1;
        b_v = '0;
        b_v[7][8] = 1'b1;
        b_v[8][8] = 1'b1;
        b_v[9][8] = 1'b1;
        bus.load   = 1'b0;
        bus.tick   = 1'b0;
        bus.board  = '0;
        bus4.load  = 1'b0;
        bus4.tick  = 1'b0;
        bus4.board = '0;

        test_reset();
        test_extinction();
        test_still_life();
        test_osc2();
        test_load_tick();
        test_saturation();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/board_monitor.md
# board_monitor

Downstream observer for the Game of Life cell array. It samples the 16x16 board of cell `alive` outputs at each generation boundary and counts generations and live population. It detects extinction (empty board) and still life (board unchanged). It feeds the status display and lets the top level stop or reseed the simulation.

## Interface
Parameters:
- `ROWS`, default 16: board rows.
- `COLS`, default 16: board columns.
- `GEN_W`, default 16: generation counter width.

Ports:
- `clk`  in  1  system clock; the only clock domain.
- `reset`  in  1  synchronous, active-high; clears all state.
- `load`  in  1  same pulse that seeds the cells; clears history and counters.
- `tick`  in  1  one-cycle strobe; `board` holds a freshly computed generation.
- `board`  in  [ROWS-1:0][COLS-1:0]  cell `alive` bits; `board[r][c]` is row r, column c.
- `gen_count`  out  GEN_W  generations accepted since the last `load`.
- `population`  out  $clog2(ROWS*COLS+1)  live cells in the last sampled board; 9 bits at the defaults.
- `extinct`  out  1  held high once the board became empty.
- `stable`  out  1  held high once the board stopped changing.
- `osc2`  out  1  held high once a period-2 oscillation is detected; present only with the macro, otherwise tied 0.
- `done`  out  1  one-cycle pulse on entry to any terminal state.

## Operation
State machine states: `IDLE`, `RUN`, `EXTINCT`, `STABLE`, `OSC2`.

- **`IDLE`** (no history; entered after reset or `load`). On `tick`:
  - Capture `board` into `prev1` and increment `gen_count`.
  - Go to `EXTINCT` if `board` is all zero, else go to `RUN`.
- **`RUN`**. On `tick`, increment `gen_count`, then evaluate in priority order:
  1. `board` all zero: go to `EXTINCT`.
  2. `board == prev1`: go to `STABLE`.
  3. With the macro, `hist_full` set and `board == prev2`: go to `OSC2`.
  4. Otherwise stay in `RUN`.
  - After evaluation: `prev2` <= `prev1`, `prev1` <= `board`, `hist_full` <= 1.
- **Terminal states** (`EXTINCT`, `STABLE`, `OSC2`):
  - `tick` is ignored.
  - `gen_count` and history are frozen.
  - The matching flag stays high until `reset` or `load`.
- **Counter width**: `gen_count` saturates at 2^GEN_W-1 and does not wrap. In saturation the FSM keeps evaluating.
- **Population**: popcount of `board`, registered on every `tick` in any state. It is not updated on non-tick cycles.
- **`load`**:
  - Sets state to `IDLE`.
  - Clears `gen_count`, `population`, all flags, `prev1`, `prev2` and `hist_full`.
  - Takes effect the cycle after it is asserted.
  - `load` and `tick` in the same cycle: `load` wins and the tick is dropped.
- **`reset`**: same effect as `load`. It has priority over both `load` and `tick`, including mid-run.

## Timing
- All outputs are registered. Reset values: `gen_count`=0, `population`=0, `extinct`=0, `stable`=0, `osc2`=0, `done`=0, state `IDLE`.
- Latency: a tick sampled at edge N updates `gen_count`, `population` and the flags, visible after edge N.
- `done` is high for exactly the one cycle following the edge that entered the terminal state.
- `tick` on consecutive cycles is legal; each one is a generation.
- No backpressure; `board` need only be valid in cycles where `tick`=1.

## Configuration
- Macro `BOARD_MONITOR_OSC2_DETECT_EN`.
- Defined:
  - `prev2` storage (ROWS*COLS flops) and the `OSC2` state are built.
  - Period-2 oscillators such as the blinker terminate with `osc2`=1 and `done` pulsed.
- Undefined:
  - `prev2` and `OSC2` are not built and `osc2` is tied 0.
  - Oscillators stay in `RUN` indefinitely.

## Structure
- Shared package `life_pkg`:
  - Constants `LIFE_ROWS`=16 and `LIFE_COLS`=16, used as parameter defaults.
  - `typedef enum logic [2:0] {IDLE, RUN, EXTINCT, STABLE, OSC2} mon_state_t`.
  - `typedef logic [LIFE_ROWS-1:0][LIFE_COLS-1:0] board_t`.
- Sub-module `pop_counter`: purely combinational adder tree, `board` to count. It has a separate testbench.
- FSM, history registers and counters live in `board_monitor`.

## Test plan
- **Reset**: reset for 2 cycles mid-`RUN` -> all outputs 0, state `IDLE`; the next tick is treated as the first generation.
- **Extinction**: `load`, then `tick` with board=0 -> next cycle `extinct`=1, `gen_count`=1, `population`=0, `done` pulses for 1 cycle. Further ticks leave `gen_count` at 1.
- **Still life**: 2x2 block at rows 5-6, cols 5-6, ticked 3 times -> after tick 2 `stable`=1, `gen_count`=2, `population`=4, `done` pulses once.
- **Period-2 oscillator**: blinker alternating horizontal and vertical at row/col 8 -> with the macro, `osc2`=1 after tick 3 with `gen_count`=3 and `population`=3. Without the macro, all flags stay 0 and `gen_count` reaches 10 after 10 ticks.
- **Simultaneous `load` and `tick`** in `RUN` -> tick dropped; next cycle `gen_count`=0 and state `IDLE`.
- **Saturation**: GEN_W=4, 20 ticks of a changing pattern -> `gen_count` holds at 15 without wrapping and flags stay 0.
